bnn_seq_classifier: RTL
=======================

BNN_SEQ_CLASSIFIER -- requirements
Module: bnn_seq_classifier

Interface
REQ-001 Parameter FEAT_CNT, default 12, number of input features.
REQ-002 Parameter FEAT_BITS, default 4, unsigned width of each feature.
REQ-003 Parameter HIDDEN_CNT, default 40, number of binary hidden neurons.
REQ-004 Parameter CLASS_CNT, default 6, number of output classes.
REQ-005 Parameter W1, default all ones, HIDDEN_CNT*FEAT_CNT bits; bit [h*FEAT_CNT+f] is the weight of feature f into neuron h (1 = +1, 0 = -1).
REQ-006 Parameter W2, default all ones, CLASS_CNT*HIDDEN_CNT bits; bit [c*HIDDEN_CNT+h] is the weight of neuron h into class c.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 features  input  FEAT_CNT*FEAT_BITS  feature f is features[f*FEAT_BITS +: FEAT_BITS].
REQ-010 in_valid  input  1  features valid.
REQ-011 in_ready  output  1  block can accept a sample.
REQ-012 prediction  output  $clog2(CLASS_CNT)  winning class index.
REQ-013 out_valid  output  1  prediction valid.
REQ-014 out_ready  input  1  consumer accepts prediction.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, HIDDEN, CLASS and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; in_valid && in_ready at an edge SHALL latch features internally and enter HIDDEN with the neuron index set to 0.
REQ-018 HIDDEN: one neuron per cycle. acc = sum over f of (W1 bit ? +x_f : -x_f), signed, width FEAT_BITS+$clog2(FEAT_CNT)+1, no overflow. hidden[h] = (acc >= 0).
REQ-019 After neuron HIDDEN_CNT-1, the FSM SHALL enter CLASS with the class index set to 0.
REQ-020 CLASS: one class per cycle. score = popcount(~(hidden ^ W2 row c)), width $clog2(HIDDEN_CNT+1). A running best is replaced only when score is strictly greater, so a tie keeps the lowest index.
REQ-021 After class CLASS_CNT-1, the FSM SHALL enter DONE with prediction = best index and out_valid = 1.
REQ-022 out_valid SHALL first be high after the (HIDDEN_CNT+CLASS_CNT)-th rising edge following the accepting edge.
REQ-023 In DONE, prediction and out_valid SHALL hold stable until out_valid && out_ready; that edge SHALL return the FSM to IDLE with out_valid = 0.
REQ-024 Changes on features or in_valid outside IDLE SHALL have no effect on the result in progress.
REQ-025 prediction SHALL hold its last value outside DONE.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, with out_valid = 0, prediction = 0, busy = 0, in_ready = 1, and all indices, hidden bits and the running best cleared.
REQ-027 Reset asserted mid-operation SHALL discard the sample in progress, with no out_valid pulse after release.
REQ-028 After rst_n deassertion, the first edge SHALL be able to accept a sample.

Verification
Scenarios use FEAT_CNT=2, FEAT_BITS=4, HIDDEN_CNT=2, CLASS_CNT=2, W1=4'b1001, W2=4'b1001.
REQ-029 features=8'h35 accepted -> hidden=2'b01, prediction=0; out_valid high exactly 4 edges after acceptance.
REQ-030 features=8'h53 -> hidden=2'b10, prediction=1.
REQ-031 features=8'h44 -> hidden=2'b11, both scores 1 (tie) -> prediction=0.
REQ-032 out_ready held 0 for 10 cycles in DONE -> prediction and out_valid stable and in_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-033 rst_n pulsed low during HIDDEN -> outputs at reset values immediately; no out_valid follows; the next sample 8'h53 -> prediction=1.
REQ-034 Back-to-back: in_valid held high with 8'h35 then 8'h53, out_ready=1 -> predictions 0 then 1, each accepted only while in_ready=1.

Source files
------------

// File: rtl/bnn_seq_classifier.sv
// Sequential binary neural network classifier: one hidden neuron per cycle,
// then one class score per cycle, with a valid/ready handshake on the result.
module bnn_seq_classifier #(
  parameter int FEAT_CNT   = 12,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 40,
  parameter int CLASS_CNT  = 6,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  W1 = '1,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2 = '1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [FEAT_CNT*FEAT_BITS-1:0]      features,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [$clog2(CLASS_CNT)-1:0]       prediction,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy
);

  localparam int AW = FEAT_BITS + $clog2(FEAT_CNT) + 1;
  localparam int SW = $clog2(HIDDEN_CNT + 1);
  localparam int HW = (HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1;
  localparam int PW = $clog2(CLASS_CNT);

  typedef enum logic [1:0] {S_IDLE, S_HIDDEN, S_CLASS, S_DONE} state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [FEAT_CNT*FEAT_BITS-1:0]   r_feat;
  logic [HW-1:0]                   r_hidx;
  logic [PW-1:0]                   r_cidx;
  logic [HIDDEN_CNT-1:0]           r_hidden;
  logic [PW-1:0]                   r_best_idx;
  logic [SW-1:0]                   r_best_score;
  logic [PW-1:0]                   r_pred;

  logic [FEAT_CNT-1:0]             w_w1_row;
  logic [HIDDEN_CNT-1:0]           w_w2_row;
  logic signed [AW-1:0]            w_acc;
  logic signed [AW-1:0]            w_x;
  logic                            w_hbit;
  logic [SW-1:0]                   w_score;
  logic                            w_better;
  logic [PW-1:0]                   w_best_idx_nxt;
  logic [SW-1:0]                   w_best_score_nxt;
  logic                            w_h_last;
  logic                            w_c_last;

  assign w_h_last = (r_hidx == HW'(HIDDEN_CNT - 1));
  assign w_c_last = (r_cidx == PW'(CLASS_CNT - 1));

  assign w_w1_row = FEAT_CNT'(W1 >> (int'(r_hidx) * FEAT_CNT));
  assign w_w2_row = HIDDEN_CNT'(W2 >> (int'(r_cidx) * HIDDEN_CNT));

  // Signed +/- sum of the latched features for the current neuron
  always_comb begin
    w_acc = '0;
    w_x   = '0;
    for (int f = 0; f < FEAT_CNT; f++) begin
      w_x = $signed({{(AW-FEAT_BITS){1'b0}}, r_feat[f*FEAT_BITS +: FEAT_BITS]});
      if (w_w1_row[f]) w_acc = w_acc + w_x;
      else             w_acc = w_acc - w_x;
    end
  end

  assign w_hbit  = ~w_acc[AW-1];
  assign w_score = SW'($countones(~(r_hidden ^ w_w2_row)));

  // Strictly-greater replacement keeps the lowest index on ties
  assign w_better         = (w_score > r_best_score);
  assign w_best_idx_nxt   = w_better ? r_cidx  : r_best_idx;
  assign w_best_score_nxt = w_better ? w_score : r_best_score;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (in_valid)  w_state_nxt = S_HIDDEN;
      S_HIDDEN: if (w_h_last)  w_state_nxt = S_CLASS;
      S_CLASS:  if (w_c_last)  w_state_nxt = S_DONE;
      S_DONE:   if (out_ready) w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_feat       <= '0;
      r_hidx       <= '0;
      r_cidx       <= '0;
      r_hidden     <= '0;
      r_best_idx   <= '0;
      r_best_score <= '0;
      r_pred       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_feat   <= features;
            r_hidx   <= '0;
            r_hidden <= '0;
          end
        end
        S_HIDDEN: begin
          r_hidden <= r_hidden | (HIDDEN_CNT'(w_hbit) << r_hidx);
          r_hidx   <= r_hidx + 1'b1;
          if (w_h_last) begin
            r_cidx       <= '0;
            r_best_idx   <= '0;
            r_best_score <= '0;
          end
        end
        S_CLASS: begin
          r_cidx       <= r_cidx + 1'b1;
          r_best_idx   <= w_best_idx_nxt;
          r_best_score <= w_best_score_nxt;
          if (w_c_last) r_pred <= w_best_idx_nxt;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign prediction = r_pred;

endmodule
